// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: state encoding, opcode classes and immediate-select values for instr_seq_ctrl.
package instr_seq_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_FWAIT  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_MWAIT  = 3'd5,
        S_INT    = 3'd6
    } state_t;
    localparam logic [1:0] OPC_ALU_S = 2'b00;
    localparam logic [1:0] OPC_ALU_L = 2'b01;
    localparam logic [1:0] OPC_MEM   = 2'b10;
    localparam logic [1:0] OPC_CTL   = 2'b11;
    localparam logic IMMSHORT = 1'b1;
    localparam logic IMMLONG  = 1'b0;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating wait-state counter; expired once the count equals limit.
module mem_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clear) count <= '0;
        else if (enable && !expired) count <= count + 1'b1;
    end
    assign expired = count == limit;
endmodule

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: instruction-cycle sequencer (fetch handshake, IR load, decode class, exec gating).
// Optional interrupt entry in FETCH is enabled by defining INSTR_SEQ_IRQ_EN.
module instr_seq_ctrl
    import instr_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPC_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir,
    input  logic        mem_rdy,
    input  logic        stall,
    input  logic        irq,
    output logic        ir_we,
    output logic        imm_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        pc_inc,
    output logic        exec_en,
    output logic        int_ack,
    output logic        bus_err,
    output logic [2:0]  state
);
    state_t cur, nxt;
    logic [OPC_W-1:0] opc;
    logic [1:0] cls;
    logic st_q, irq_ok, take_irq, waiting, expired, timeout, done, rd_c;
    assign opc = ir[15 -: OPC_W];
    assign cls = opc[OPC_W-1 -: 2];
    assign waiting = cur == S_FWAIT || cur == S_MWAIT;
    assign timeout = waiting && !mem_rdy && expired;
    assign done = (cur == S_EXEC && !stall) || (cur == S_MWAIT && mem_rdy);
`ifdef INSTR_SEQ_IRQ_EN
    assign take_irq = irq && irq_ok;
`else
    logic unused_irq;
    assign take_irq = 1'b0;
    assign unused_irq = ^{irq, irq_ok};
`endif
    logic unused_ir;
    assign unused_ir = ^{opc[OPC_W-4:0], ir[15-OPC_W:0]};

    mem_wait_timer #(.W(8)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!waiting),
        .enable  (waiting && !mem_rdy),
        .limit   (8'(MEM_TIMEOUT)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_FETCH;
            imm_sel <= 1'b0;
            st_q    <= 1'b0;
            bus_err <= 1'b0;
            irq_ok  <= 1'b1;
        end else begin
            cur     <= nxt;
            bus_err <= bus_err | timeout;
            irq_ok  <= done ? 1'b1 : (cur == S_INT ? 1'b0 : irq_ok);
            if (cur == S_DECODE) begin
                imm_sel <= (cls == OPC_ALU_L || cls == OPC_CTL) ? IMMLONG : IMMSHORT;
                st_q    <= opc[OPC_W-3];
            end
        end
    end

    // Requests are held through the wait states and dropped only on the timeout cycle.
    always_comb begin
        nxt     = cur;
        rd_c    = 1'b0;
        mem_wr  = 1'b0;
        ir_we   = 1'b0;
        exec_en = 1'b0;
        int_ack = 1'b0;
        case (cur)
            S_FETCH: begin
                rd_c = !take_irq;
                nxt  = take_irq ? S_INT : S_FWAIT;
            end
            S_FWAIT: begin
                rd_c  = !timeout;
                ir_we = mem_rdy;
                nxt   = mem_rdy ? S_DECODE : (expired ? S_FETCH : S_FWAIT);
            end
            S_DECODE: nxt = cls == OPC_MEM ? S_MEM : S_EXEC;
            S_EXEC: begin
                exec_en = !stall;
                nxt     = stall ? S_EXEC : S_FETCH;
            end
            S_MEM: begin
                rd_c   = !st_q;
                mem_wr = st_q;
                nxt    = S_MWAIT;
            end
            S_MWAIT: begin
                rd_c    = !st_q && !timeout;
                mem_wr  = st_q && !timeout;
                exec_en = mem_rdy && !st_q;
                nxt     = (mem_rdy || expired) ? S_FETCH : S_MWAIT;
            end
            S_INT: begin
                int_ack = 1'b1;
                nxt     = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // FETCH is the reset state, so the read strobe is masked while reset is held.
    assign mem_rd = rd_c && rst_n;
    assign pc_inc = ir_we;
    assign state  = cur;
endmodule
